mux_nx1_pipe: RTL and testbench
===============================

MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning the number of input channels (2..16).
REQ-003 The block SHALL have parameter SELW, default 2, meaning the select width, with SELW = clog2(N).
REQ-004 The block SHALL have parameter RR_MODE, default 0, meaning 0 = external select and 1 = round-robin arbitration.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of the output stage and the arbitration pointer.
REQ-008 The block SHALL have port sel, input, SELW bits: the channel select, used only when RR_MODE=0.
REQ-009 The block SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_valid, input, N bits: per-channel data valid.
REQ-011 The block SHALL have port in_ready, output, N bits: per-channel accept, one-hot or zero.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-013 The block SHALL have port out_chan, output, SELW bits: index of the channel that supplied out_data.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data and out_chan are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the downstream accepts on out_valid & out_ready.

Function
REQ-016 The output stage SHALL be a single register entry, with load_en = !flush & (!out_valid | out_ready).
REQ-017 When RR_MODE=0, grant SHALL be channel sel if sel < N and in_valid[sel]=1; otherwise there is no grant.
REQ-018 When RR_MODE=1, grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
REQ-019 in_ready[i] SHALL be 1 only when load_en=1 and grant=i, and in_ready SHALL be combinational with no dependency on out_data.
REQ-020 On in_valid[g] & in_ready[g], out_data, out_chan and out_valid SHALL take in_data[g], g and 1 on the next edge, giving a latency of 1 cycle.
REQ-021 If load_en=1 and there is no grant, then out_valid SHALL become 0 on the next edge if the prior entry drained, otherwise it holds.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold stable, and in_ready SHALL be all 0.
REQ-023 Simultaneous drain and load SHALL sustain 1 transfer/cycle with no bubble.
REQ-024 The RR pointer ptr SHALL advance to (g+1) mod N only on an accepted transfer, wrapping N-1 to 0, and SHALL hold otherwise.
REQ-025 In RR mode, a continuously valid channel SHALL wait at most N-1 accepted transfers before it is granted.
REQ-026 When flush=1, the next edge SHALL give out_valid=0 and ptr=0, in_ready SHALL be all 0 that cycle, and flush SHALL take priority over a simultaneous load or drain.
REQ-027 A change of sel while out_valid=1 and the stage is stalled SHALL NOT alter the held output.
REQ-028 out_data SHALL be a don't-care while out_valid=0, but SHALL retain its last value with no X injection.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=0 and in_ready=0, independent of clk.
REQ-030 Reset asserted mid-transfer SHALL discard the held entry, and no transfer SHALL be reported after rst_n returns to 1.
REQ-031 The first load after reset release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-032 Fixed mode, N=4: sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100, and the next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
REQ-033 Backpressure: with out_valid=1 and out_ready=0 for 3 cycles while sel and in_data change -> outputs stable and in_ready=0; out_ready=1 -> the next entry loads in the same cycle.
REQ-034 RR mode, N=4: in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 RR skip and wrap: ptr=3, in_valid=4'b0010 -> grant 1, and ptr becomes 2.
REQ-036 flush=1 together with a valid grant and out_ready=1 -> no in_ready, and the next cycle out_valid=0 and ptr=0.
REQ-037 rst_n pulsed low between edges while out_valid=1 -> out_valid=0 immediately, and out_valid stays 0 until the first post-release accepted transfer.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// ---------------------------------------------------------------------------
// mux_nx1_pipe
// N-to-1 channel multiplexer with a single registered output entry.
// Channel choice is either an external select (RR_MODE=0) or a rotating
// round-robin pointer (RR_MODE=1).
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of output entry and round-robin pointer
//   sel        external channel select (RR_MODE=0 only)
//   in_data    N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected data
//   out_chan   channel index that supplied out_data
//   out_valid  output entry is valid
//   out_ready  downstream accept
// ---------------------------------------------------------------------------
module mux_nx1_pipe #(
   parameter int WIDTH   = 32,
   parameter int N       = 4,
   parameter int SELW    = 2,
   parameter int RR_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam logic [SELW:0] N_L = (SELW+1)'(N);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  grant;
   logic [SELW-1:0]  ptr_nxt;
   logic             grant_vld;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] grant_data;
   logic [SELW:0]    rr_idx;

   // The entry may be replaced when it is empty or being drained this cycle.
   assign load_en = !flush && (!out_valid || out_ready);
   assign xfer    = load_en && grant_vld;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      rr_idx    = '0;
      if (RR_MODE == 0) begin
         // sel beyond N-1 is never a grant, even for non-power-of-two N
         if ({1'b0, sel} < N_L) begin
            grant     = sel;
            grant_vld = in_valid[sel];
         end
      end else begin
         // first valid channel starting at ptr, wrapping modulo N
         for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr} + (SELW+1)'(k);
            if (rr_idx >= N_L)
               rr_idx = rr_idx - N_L;
            if (!grant_vld && in_valid[rr_idx[SELW-1:0]]) begin
               grant_vld = 1'b1;
               grant     = rr_idx[SELW-1:0];
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i))
            grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // in_ready is forced low while reset is asserted, independent of clk.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++)
         in_ready[i] = rst_n && xfer && (grant == SELW'(i));
   end

   assign ptr_nxt = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (flush) begin
         // out_data/out_chan keep their last value; only validity is cleared
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (grant_vld) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant;
            if (RR_MODE != 0)
               ptr <= ptr_nxt;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_pipe
// Directed bench for mux_nx1_pipe: one fixed-select instance and one
// round-robin instance. Accepted inputs are queued as expected output
// entries and compared when the corresponding DUT drains its output.
// ---------------------------------------------------------------------------
module tb_mux_nx1_pipe;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  in_data;

   logic            flush_f, flush_r;
   logic [SW-1:0]   sel_f, sel_r;
   logic [N-1:0]    iv_f, iv_r, rdy_f, rdy_r;
   logic [W-1:0]    od_f, od_r;
   logic [SW-1:0]   oc_f, oc_r;
   logic            ov_f, ov_r, ordy_f, ordy_r;

   always #5 clk = ~clk;

   mux_nx1_pipe #(.WIDTH(W), .N(N), .SELW(SW), .RR_MODE(0)) dut_f (
      .clk(clk), .rst_n(rst_n), .flush(flush_f), .sel(sel_f),
      .in_data(in_data), .in_valid(iv_f), .in_ready(rdy_f),
      .out_data(od_f), .out_chan(oc_f), .out_valid(ov_f), .out_ready(ordy_f)
   );

   mux_nx1_pipe #(.WIDTH(W), .N(N), .SELW(SW), .RR_MODE(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .flush(flush_r), .sel(sel_r),
      .in_data(in_data), .in_valid(iv_r), .in_ready(rdy_r),
      .out_data(od_r), .out_chan(oc_r), .out_valid(ov_r), .out_ready(ordy_r)
   );

   typedef struct packed {
      logic [SW-1:0] chan;
      logic [W-1:0]  data;
   } ent_t;

   ent_t sb_f[$];
   ent_t sb_r[$];
   int   vectors = 0;
   int   errors  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk_out(input bit rr, input string tag, input logic ov,
                          input logic [W-1:0] od, input logic [SW-1:0] oc);
      chk({tag, "/out_valid"}, 64'(rr ? ov_r : ov_f), 64'(ov));
      chk({tag, "/out_data"},  64'(rr ? od_r : od_f), 64'(od));
      chk({tag, "/out_chan"},  64'(rr ? oc_r : oc_f), 64'(oc));
   endtask

   // One cycle: drive at the falling edge, check in_ready and the drained
   // entry 1 time unit later, update the scoreboard, wait one clock.
   task automatic step(input bit rr, input logic fl, input logic [SW-1:0] s,
                       input logic [N-1:0] iv, input logic ordy,
                       input logic [N-1:0] exp_rdy, input string tag);
      logic [N-1:0] rdy_obs;
      logic         ov_obs;
      ent_t         got, e;
      int           sz;
      if (rr) begin
         flush_r = fl; sel_r = s; iv_r = iv; ordy_r = ordy;
      end else begin
         flush_f = fl; sel_f = s; iv_f = iv; ordy_f = ordy;
      end
      #1;
      if (rr) begin
         rdy_obs = rdy_r; ov_obs = ov_r; got = {oc_r, od_r}; sz = sb_r.size();
      end else begin
         rdy_obs = rdy_f; ov_obs = ov_f; got = {oc_f, od_f}; sz = sb_f.size();
      end
      chk({tag, "/in_ready"}, 64'(rdy_obs), 64'(exp_rdy));
      if (fl) begin
         if (rr) sb_r.delete(); else sb_f.delete();
      end else begin
         if (ov_obs && ordy) begin
            chk({tag, "/sb_has_entry"}, 64'(sz != 0), 64'd1);
            if (sz != 0) begin
               if (rr) e = sb_r.pop_front(); else e = sb_f.pop_front();
               chk({tag, "/drain_chan"}, 64'(got.chan), 64'(e.chan));
               chk({tag, "/drain_data"}, 64'(got.data), 64'(e.data));
            end
         end
         if (exp_rdy != '0) begin
            e.chan = SW'(oh_idx(exp_rdy));
            e.data = in_data[oh_idx(exp_rdy)*W +: W];
            if (rr) sb_r.push_back(e); else sb_f.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      flush_f = 1'b0; sel_f = '0; iv_f = '1; ordy_f = 1'b1;
      flush_r = 1'b0; sel_r = '0; iv_r = '1; ordy_r = 1'b1;

      // reset state, in_ready held low despite valid inputs
      repeat (2) @(negedge clk);
      #1;
      chk_out(0, "rst_f", 1'b0, '0, '0);
      chk_out(1, "rst_r", 1'b0, '0, '0);
      chk("rst_f/in_ready", 64'(rdy_f), 64'd0);
      chk("rst_r/in_ready", 64'(rdy_r), 64'd0);
      @(negedge clk);
      iv_f = '0; iv_r = '0;
      rst_n = 1'b1;

      // fixed select of channel 2
      in_data = '0;
      in_data[2*W +: W] = 32'hDEADBEEF;
      step(0, 0, 2'd2, 4'b0100, 1, 4'b0100, "f_sel2");
      chk_out(0, "f_sel2_out", 1'b1, 32'hDEADBEEF, 2'd2);
      step(0, 0, 2'd0, 4'b0000, 1, 4'b0000, "f_drain");
      chk("f_drain/out_valid", 64'(ov_f), 64'd0);

      // backpressure: held stable while sel and data change
      in_data[1*W +: W] = 32'h11111111;
      step(0, 0, 2'd1, 4'b0010, 0, 4'b0010, "bp_load");
      for (int k = 0; k < 3; k++) begin
         chk_out(0, "bp_hold", 1'b1, 32'h11111111, 2'd1);
         in_data = {$urandom, $urandom, $urandom, $urandom};
         step(0, 0, SW'((k + 2) % N), 4'b1111, 0, 4'b0000, "bp_stall");
      end
      chk_out(0, "bp_hold_end", 1'b1, 32'h11111111, 2'd1);
      in_data[3*W +: W] = 32'h33333333;
      step(0, 0, 2'd3, 4'b1000, 1, 4'b1000, "bp_release");
      chk_out(0, "bp_next", 1'b1, 32'h33333333, 2'd3);

      // back-to-back drain and load
      for (int k = 0; k < N; k++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         step(0, 0, SW'(k), 4'b1111, 1, 4'(4'b0001 << k), "b2b");
         chk("b2b/out_valid", 64'(ov_f), 64'd1);
      end
      step(0, 0, 2'd0, 4'b1110, 1, 4'b0000, "f_nogrant");
      chk("f_nogrant/out_valid", 64'(ov_f), 64'd0);

      // flush beats a simultaneous load and drain
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(0, 0, 2'd0, 4'b0001, 1, 4'b0001, "fl_load");
      chk("fl_load/out_valid", 64'(ov_f), 64'd1);
      step(0, 1, 2'd0, 4'b0001, 1, 4'b0000, "fl_f");
      chk("fl_f/out_valid", 64'(ov_f), 64'd0);

      // reset pulse between edges discards the held entry
      step(0, 0, 2'd1, 4'b0010, 0, 4'b0010, "rst_load");
      chk("rst_load/out_valid", 64'(ov_f), 64'd1);
      iv_f = '0; ordy_f = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_out(0, "rst_async", 1'b0, '0, '0);
      sb_f.delete();
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_post/out_valid", 64'(ov_f), 64'd0);
      step(0, 0, 2'd0, 4'b0000, 1, 4'b0000, "rst_idle");
      chk("rst_idle/out_valid", 64'(ov_f), 64'd0);
      step(0, 0, 2'd3, 4'b1000, 1, 4'b1000, "rst_reload");
      chk_out(0, "rst_reload_out", 1'b1, in_data[3*W +: W], 2'd3);
      step(0, 0, 2'd0, 4'b0000, 1, 4'b0000, "rst_drain");

      // round-robin rotation 0,1,2,3,0 with all channels valid
      for (int k = 0; k < 5; k++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         step(1, 0, 2'd0, 4'b1111, 1, 4'(4'b0001 << (k % N)), "rr_seq");
         chk("rr_seq/out_valid", 64'(ov_r), 64'd1);
      end
      // stall holds output and pointer
      step(1, 0, 2'd0, 4'b1111, 0, 4'b0000, "rr_stall");
      step(1, 0, 2'd3, 4'b1111, 0, 4'b0000, "rr_stall");
      chk_out(1, "rr_stall_out", 1'b1, sb_r[0].data, 2'd0);
      step(1, 0, 2'd0, 4'b1111, 1, 4'b0010, "rr_resume");
      step(1, 0, 2'd0, 4'b0000, 1, 4'b0000, "rr_drain");
      chk("rr_drain/out_valid", 64'(ov_r), 64'd0);
      // ptr=2: channel 2 granted, ptr -> 3
      step(1, 0, 2'd0, 4'b0100, 1, 4'b0100, "rr_to3");
      // ptr=3: skip 3 and 0, wrap to 1, ptr -> 2
      step(1, 0, 2'd0, 4'b0010, 1, 4'b0010, "rr_wrap");
      step(1, 0, 2'd0, 4'b1111, 1, 4'b0100, "rr_ptr2");
      // flush clears entry and pointer
      step(1, 1, 2'd0, 4'b1111, 1, 4'b0000, "rr_flush");
      chk("rr_flush/out_valid", 64'(ov_r), 64'd0);
      step(1, 0, 2'd0, 4'b1111, 1, 4'b0001, "rr_ptr0");
      step(1, 0, 2'd0, 4'b0000, 1, 4'b0000, "rr_end");

      step(0, 0, 2'd0, 4'b0000, 1, 4'b0000, "idle");
      chk("end/sb_f_left", 64'(sb_f.size()), 64'd0);
      chk("end/sb_r_left", 64'(sb_r.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
